// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: words stream in through an auto-incrementing
// loader in LOAD, then the fetch stage reads them with 1-cycle latency in RUN.
module instr_mem_loadable #(
    parameter int              IW    = 16,
    parameter int              AW    = 8,
    parameter int              DEPTH = 256,
    parameter logic [IW-1:0]   NOP   = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_data,
    input  logic          load_done,
    input  logic          fetch_en,
    input  logic [AW-1:0] fetch_addr,
    input  logic          stall,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    output logic          fetch_err,
    output logic          running,
    output logic [AW:0]   prog_len,
    output logic          load_ovf
);

    localparam int          IDXW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   mem [DEPTH];
    logic [AW:0]     wr_ptr;
    logic [IDXW-1:0] wr_idx;
    logic [IDXW-1:0] rd_idx;
    logic            in_load;
    logic            wr_ok;
    logic            fetch_hit;

    // wr_ptr doubles as the program length, so a hit implies rd_idx < DEPTH
    assign in_load   = (state == ST_LOAD);
    assign wr_ok     = in_load && wr_en && !load_start && (wr_ptr < DEPTH_L);
    assign fetch_hit = ({1'b0, fetch_addr} < wr_ptr);
    assign wr_idx    = wr_ptr[IDXW-1:0];
    assign rd_idx    = fetch_addr[IDXW-1:0];
    assign running   = (state == ST_RUN);
    assign prog_len  = wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD: begin
                if (!load_start && load_done) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    state_next = ST_LOAD;
                end
            end
            default: state_next = ST_LOAD;
        endcase
    end

    // Array is deliberately not reset; words past prog_len are never returned
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr       <= NOP;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            wr_ptr      <= '0;
            load_ovf    <= 1'b0;
        end else if (in_load) begin
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
            if (load_start) begin
                wr_ptr   <= '0;
                load_ovf <= 1'b0;
            end else if (wr_en) begin
                if (wr_ptr < DEPTH_L) begin
                    wr_ptr <= wr_ptr + ONE;
                end else begin
                    load_ovf <= 1'b1;
                end
            end
        end else begin
            if (load_start) begin
                wr_ptr      <= '0;
                load_ovf    <= 1'b0;
                instr_valid <= 1'b0;
                fetch_err   <= 1'b0;
            end else if (!stall) begin
                if (fetch_en && fetch_hit) begin
                    instr       <= mem[rd_idx];
                    instr_valid <= 1'b1;
                    fetch_err   <= 1'b0;
                end else if (fetch_en) begin
                    instr       <= NOP;
                    instr_valid <= 1'b1;
                    fetch_err   <= 1'b1;
                end else begin
                    instr_valid <= 1'b0;
                    fetch_err   <= 1'b0;
                end
            end
        end
    end

endmodule
